piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 137 +++++++++++++
 tb/tb_piso_serializer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out driver for an external
// shift-register chain (e.g. 74HC595 style). Each accepted word is shifted
// out MSB first, one bit every DIV clk cycles, with an sclk rising edge in
// the middle of every bit. A DIV-cycle latch strobe follows the bits, and
// then a one-cycle done pulse is issued.
//
// Optional feature: define PISO_PARITY_EN to append an even-parity bit
// (XOR of the captured word) after the data bits, giving WIDTH+1 bits per frame.
module piso_serializer #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             sclk,
    output logic             latch,
    output logic             busy,
    output logic             done
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif

    // Bit counter must be able to hold WIDTH+1; divide counter must hold DIV-1.
    localparam int BCW = $clog2(WIDTH + 2);
    localparam int DCW = (DIV > 2) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    state_t                  state;
    logic [FRAME_BITS-1:0]   shreg;
    logic [BCW-1:0]          bit_cnt;
    logic [DCW-1:0]          div_cnt;
    logic [FRAME_BITS-1:0]   frame_word;
    logic                    last_div;
    logic                    half_div;
    logic                    last_bit;

    // The word as it will go onto the wire, parity appended when enabled.
`ifdef PISO_PARITY_EN
    assign frame_word = {din, ^din};
`else
    assign frame_word = din;
`endif

    assign din_ready = (state == IDLE);
    assign last_div  = (div_cnt == DCW'(DIV - 1));
    assign half_div  = (div_cnt == DCW'(DIV / 2 - 1));
    assign last_bit  = (bit_cnt == BCW'(FRAME_BITS - 1));

    // Frame sequencer: state, counters, shift register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            ser_out <= 1'b0;
            sclk    <= 1'b0;
            latch   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (din_valid) begin
                        // First bit is presented immediately so it is
                        // stable for its full DIV-cycle period.
                        state   <= SHIFT;
                        shreg   <= frame_word;
                        ser_out <= frame_word[FRAME_BITS-1];
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        sclk    <= 1'b0;
                        busy    <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (last_div) begin
                        div_cnt <= '0;
                        sclk    <= 1'b0;
                        if (last_bit) begin
                            state   <= LATCH;
                            ser_out <= 1'b0;
                            latch   <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                            shreg   <= shreg << 1;
                            ser_out <= shreg[FRAME_BITS-2];
                        end
                    end else begin
                        div_cnt <= div_cnt + DCW'(1);
                        // Raise sclk for the second half of the bit period.
                        if (half_div) begin
                            sclk <= 1'b1;
                        end
                    end
                end

                LATCH: begin
                    if (last_div) begin
                        div_cnt <= '0;
                        state   <= IDLE;
                        latch   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + DCW'(1);
                    end
                end

                default: begin
                    state   <= IDLE;
                    ser_out <= 1'b0;
                    sclk    <= 1'b0;
                    latch   <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer (WIDTH=8, DIV=4). Expected per-cycle outputs come
// from a frame-timing model computed with plain arithmetic on the cycle number.
// Honours PISO_PARITY_EN the same way as the design.
module tb_piso_serializer;

    localparam int WIDTH = 8;
    localparam int DIV   = 4;
`ifdef PISO_PARITY_EN
    localparam int FB = WIDTH + 1;
`else
    localparam int FB = WIDTH;
`endif
    // Cycles from accept to the done cycle inclusive.
    localparam int FT = FB * DIV + DIV + 1;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             ser_out;
    logic             sclk;
    logic             latch;
    logic             busy;
    logic             done;
    logic [5:0]       obs;

    int checks = 0;
    int errors = 0;

    piso_serializer #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .ser_out   (ser_out),
        .sclk      (sclk),
        .latch     (latch),
        .busy      (busy),
        .done      (done)
    );

    assign obs = {ser_out, sclk, latch, busy, done, din_ready};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected {ser_out,sclk,latch,busy,done,din_ready} in cycle c after
    // the accept edge of word w (c<=0 or past the frame means idle).
    function automatic logic [5:0] model(input logic [WIDTH-1:0] w, input int c);
        int   idx;
        int   ph;
        logic b;
        if (c >= 1 && c <= FB * DIV) begin
            idx = (c - 1) / DIV;
            ph  = (c - 1) % DIV;
            b   = (idx < WIDTH) ? w[WIDTH-1-idx] : ^w;
            return {b, (ph >= DIV / 2), 1'b0, 1'b1, 1'b0, 1'b0};
        end else if (c > FB * DIV && c <= FB * DIV + DIV) begin
            return 6'b001100;
        end else if (c == FT) begin
            return 6'b000011;
        end
        return 6'b000001;
    endfunction

    task automatic test_reset;
        rst_n     = 1'b0;
        din_valid = 1'b1;
        din       = 8'hFF;
        repeat (3) @(negedge clk);
        checks++; if (ser_out !== 1'b0) begin errors++; $display("FAIL reset_ser_out got=%b exp=0", ser_out); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
        checks++; if (latch !== 1'b0) begin errors++; $display("FAIL reset_latch got=%b exp=0", latch); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_din_ready got=%b exp=1", din_ready); end
        din_valid = 1'b0;
        rst_n     = 1'b1;
        $display("test_reset: outputs checked under reset");
    endtask

    task automatic test_single_frame;
        logic [WIDTH-1:0] words [6];
        logic [5:0]       exp;
        words[0] = 8'hA5;
        words[1] = 8'h07;
        for (int i = 2; i < 6; i++) words[i] = WIDTH'($urandom);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (din_ready !== 1'b1) begin
                errors++; $display("FAIL frame_ready_before_accept word=%h got=%b exp=1", words[i], din_ready);
            end
            din       = words[i];
            din_valid = 1'b1;
            for (int c = 1; c <= FT + 2; c++) begin
                @(negedge clk);
                if (c == 1) din_valid = 1'b0;
                exp = model(words[i], c);
                checks++;
                if (obs !== exp) begin
                    errors++; $display("FAIL frame word=%h cycle=%0d got=%b exp=%b", words[i], c, obs, exp);
                end
            end
            $display("test_single_frame: word %h checked over %0d cycles", words[i], FT + 2);
        end
    endtask

    task automatic test_back_to_back;
        logic [WIDTH-1:0] w1;
        logic [WIDTH-1:0] w2;
        logic [5:0]       exp;
        w1 = 8'h3C;
        w2 = 8'hC3;
        @(negedge clk);
        din       = w1;
        din_valid = 1'b1;
        for (int c = 1; c <= 2 * FT + 1; c++) begin
            @(negedge clk);
            if (c == 1) din = w2;
            if (c == FT + 1) din_valid = 1'b0;
            exp = (c <= FT) ? model(w1, c) : model(w2, c - FT);
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL back_to_back cycle=%0d got=%b exp=%b", c, obs, exp);
            end
        end
        $display("test_back_to_back: %h then %h checked", w1, w2);
    endtask

    task automatic test_ignore_busy;
        logic [5:0] exp;
        @(negedge clk);
        din       = 8'h00;
        din_valid = 1'b1;
        for (int c = 1; c <= 2 * FT + 1; c++) begin
            @(negedge clk);
            if (c == 1) din_valid = 1'b0;
            exp = (c <= FT) ? model(8'h00, c) : model(8'hFF, c - FT);
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL ignore_busy cycle=%0d got=%b exp=%b", c, obs, exp);
            end
            if (c == 10) begin
                din       = 8'hFF;
                din_valid = 1'b1;
            end
            if (c == FT + 1) din_valid = 1'b0;
        end
        $display("test_ignore_busy: FF offered in cycle 10 of 00 frame");
    endtask

    task automatic test_reset_mid_frame;
        logic [WIDTH-1:0] w;
        logic [5:0]       exp;
        @(negedge clk);
        din       = 8'hA5;
        din_valid = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) din_valid = 1'b0;
            exp = model(8'hA5, c);
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL mid_reset_pre cycle=%0d got=%b exp=%b", c, obs, exp);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 6'b000001) begin
            errors++; $display("FAIL mid_reset_async got=%b exp=000001", obs);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== 6'b000001) begin
                errors++; $display("FAIL mid_reset_quiet cycle=%0d got=%b exp=000001", c, obs);
            end
        end
        // First valid edge after reset must accept.
        w         = WIDTH'($urandom);
        din       = w;
        din_valid = 1'b1;
        for (int c = 1; c <= FT + 1; c++) begin
            @(negedge clk);
            if (c == 1) din_valid = 1'b0;
            exp = model(w, c);
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL post_reset_frame word=%h cycle=%0d got=%b exp=%b", w, c, obs, exp);
            end
        end
        $display("test_reset_mid_frame: abandoned A5, then accepted %h", w);
    endtask

    initial begin
        rst_n     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_ignore_busy;
        test_reset_mid_frame;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
